// File: rtl/interval_arbiter4_pkg.sv
// Shared definitions for the interval_arbiter4 scheduler: FSM state encoding,
// requester count, default counter width and small arbitration helpers.
package interval_arbiter4_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int NREQ      = 2;

    // 2'd3 is unused and recovers to IDLE in the FSM default branch.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Winner index: a lone requester wins, a tie goes to the favoured one.
    function automatic logic pick_winner(input logic [NREQ-1:0] req, input logic pri);
        case (req)
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return pri;
        endcase
    endfunction

    // One-hot grant vector for a requester index.
    function automatic logic [NREQ-1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/interval_arbiter4_if.sv
// Request/grant bus between the requesters (master) and interval_arbiter4
// (slave). ABORT/ABORTED exist only when INTERVAL_ARBITER4_ABORT_EN is defined.
interface interval_arbiter4_if
    import interval_arbiter4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [NREQ-1:0]  REQ;
    logic [WIDTH-1:0] LEN0;
    logic [WIDTH-1:0] LEN1;
    logic [NREQ-1:0]  ACK;
    logic [NREQ-1:0]  GRANT;
    logic [NREQ-1:0]  DONE;
    logic             BUSY;
    logic [WIDTH-1:0] COUNT;
`ifdef INTERVAL_ARBITER4_ABORT_EN
    logic             ABORT;
    logic             ABORTED;
`endif

    modport master (
`ifdef INTERVAL_ARBITER4_ABORT_EN
        output ABORT,
        input  ABORTED,
`endif
        output REQ, LEN0, LEN1,
        input  ACK, GRANT, DONE, BUSY, COUNT
    );

    modport slave (
`ifdef INTERVAL_ARBITER4_ABORT_EN
        input  ABORT,
        output ABORTED,
`endif
        input  REQ, LEN0, LEN1,
        output ACK, GRANT, DONE, BUSY, COUNT
    );

endinterface

// File: rtl/interval_counter.sv
// Shared interval counter datapath: WIDTH-bit register with incrementer and
// carry-out, synchronous clear that also loads the interval length, and a
// terminal flag raised on the last tick of the loaded interval.
module interval_counter
    import interval_arbiter4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] len_i,
    output logic [WIDTH-1:0] count_o,
    output logic             term_o
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] len_q;
    logic [WIDTH-1:0] sum;
    logic             carry;

    assign {carry, sum} = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};

    // Clear wins over increment; otherwise hold.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = sum;
        end
    end

    // Length zero means a full 2^WIDTH-tick interval: the last tick is the one
    // whose increment carries out of the register.
    assign term_o = (len_q == '0) ? carry : (count_q == (len_q - WIDTH'(1)));

    // Counter register, cleared immediately on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Interval length is captured together with the clear at grant time.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            len_q <= len_i;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/interval_arbiter4.sv
// interval_arbiter4: round-robin scheduler sharing one interval counter between
// two requesters. IDLE samples REQ and grants, RUN counts the interval, FIN
// pulses DONE for one cycle. Optional feature macro INTERVAL_ARBITER4_ABORT_EN
// adds ABORT (cut a running interval short) and ABORTED (flags such a DONE).
module interval_arbiter4
    import interval_arbiter4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               CLK,
    input  logic               ASYNCRESET,
    interval_arbiter4_if.slave bus
);
    state_t           state_q;
    logic             pri_q;
    logic             owner_q;
    logic [NREQ-1:0]  ack_q;
    logic [NREQ-1:0]  grant_q;
    logic [NREQ-1:0]  done_q;
    logic             busy_q;

    logic             win;
    logic [WIDTH-1:0] len_win;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_term;
    logic             abort_w;

    assign win     = pick_winner(bus.REQ, pri_q);
    assign len_win = win ? bus.LEN1 : bus.LEN0;
    assign cnt_clr = (state_q == IDLE) && (|bus.REQ);
    assign cnt_en  = (state_q == RUN);

`ifdef INTERVAL_ARBITER4_ABORT_EN
    logic aborted_q;
    assign abort_w     = bus.ABORT;
    assign bus.ABORTED = aborted_q;
`else
    assign abort_w = 1'b0;
`endif

    interval_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk_i   (CLK),
        .rst_i   (ASYNCRESET),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .len_i   (len_win),
        .count_o (bus.COUNT),
        .term_o  (cnt_term)
    );

    // Arbiter FSM with registered handshake outputs and round-robin pointer.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state_q   <= IDLE;
            pri_q     <= 1'b0;
            owner_q   <= 1'b0;
            ack_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
`ifdef INTERVAL_ARBITER4_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            ack_q     <= '0;
            done_q    <= '0;
`ifdef INTERVAL_ARBITER4_ABORT_EN
            aborted_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (|bus.REQ) begin
                        owner_q <= win;
                        ack_q   <= onehot(win);
                        grant_q <= onehot(win);
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (cnt_term || abort_w) begin
                        grant_q <= '0;
                        done_q  <= onehot(owner_q);
`ifdef INTERVAL_ARBITER4_ABORT_EN
                        aborted_q <= abort_w;
`endif
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    pri_q   <= ~owner_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ACK   = ack_q;
    assign bus.GRANT = grant_q;
    assign bus.DONE  = done_q;
    assign bus.BUSY  = busy_q;

endmodule
